// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the decode-stage hazard/sequencing controller:
// cycle-class encodings and default widths.
package pipeline_ctrl_pkg;

  localparam int REG_W_DEFAULT = 5;
  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FLUSH  = 2'd2,
    FREEZE = 2'd3
  } ctrl_class_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Decode-side bundle of the pipeline controller: the decode/writeback/memory
// inputs it watches and the enables and status it drives back.
interface pipeline_ctrl_if
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) ();

  logic             i_id_valid;
  logic [REG_W-1:0] i_id_rs1_num;
  logic [REG_W-1:0] i_id_rs2_num;
  logic             i_id_uses_rs1;
  logic             i_id_uses_rs2;
  logic [REG_W-1:0] i_id_rd_num;
  logic             i_id_writes_rd;
  logic             i_b_taken;
  logic             i_wb_valid;
  logic [REG_W-1:0] i_wb_rd_num;
  logic             i_mem_busy;
  logic             i_cnt_clr;

  logic             o_pc_en;
  logic             o_if_id_en;
  logic             o_id_kill;
  logic             o_hold;
  logic             o_issue;
  logic [1:0]       o_state;
  logic [CNT_W-1:0] o_stall_cnt;

  modport master (
    output i_id_valid, i_id_rs1_num, i_id_rs2_num, i_id_uses_rs1, i_id_uses_rs2,
           i_id_rd_num, i_id_writes_rd, i_b_taken, i_wb_valid, i_wb_rd_num,
           i_mem_busy, i_cnt_clr,
    input  o_pc_en, o_if_id_en, o_id_kill, o_hold, o_issue, o_state, o_stall_cnt
  );

  modport slave (
    input  i_id_valid, i_id_rs1_num, i_id_rs2_num, i_id_uses_rs1, i_id_uses_rs2,
           i_id_rd_num, i_id_writes_rd, i_b_taken, i_wb_valid, i_wb_rd_num,
           i_mem_busy, i_cnt_clr,
    output o_pc_en, o_if_id_en, o_id_kill, o_hold, o_issue, o_state, o_stall_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_scoreboard.sv
// Per-register busy bits for in-flight writes, with one set port, one clear
// port and three combinational lookups. Register 0 is never marked busy.
module pipeline_ctrl_scoreboard #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_num,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_num,
  input  logic [REG_W-1:0] rs1_num,
  input  logic [REG_W-1:0] rs2_num,
  input  logic [REG_W-1:0] rd_num,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             rd_busy
);

  localparam int DEPTH = 2 ** REG_W;

  logic [DEPTH-1:0] busy;

  // The set is written after the clear so a same-cycle set of that register wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (clr_en && (clr_num != '0)) busy[clr_num] <= 1'b0;
      if (set_en && (set_num != '0)) busy[set_num] <= 1'b1;
    end
  end

  assign rs1_busy = busy[rs1_num];
  assign rs2_busy = busy[rs2_num];
  assign rd_busy  = busy[rd_num];

endmodule

// File: rtl/pipeline_ctrl.sv
// Decode-stage hazard controller: classifies each cycle as RUN, STALL, FLUSH
// or FREEZE and drives the PC / IF-ID / ID-EX controls and a stall counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input logic            i_clk,
  input logic            i_rst_n,
  pipeline_ctrl_if.slave bus
);

  logic             rs1_busy;
  logic             rs2_busy;
  logic             rd_busy;
  logic             hazard;
  logic             issue;
  logic             flush_pending;
  logic [CNT_W-1:0] stall_cnt;
  ctrl_class_t      cls;

  pipeline_ctrl_scoreboard #(.REG_W(REG_W)) sb (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .set_en   (issue & bus.i_id_writes_rd),
    .set_num  (bus.i_id_rd_num),
    .clr_en   (bus.i_wb_valid),
    .clr_num  (bus.i_wb_rd_num),
    .rs1_num  (bus.i_id_rs1_num),
    .rs2_num  (bus.i_id_rs2_num),
    .rd_num   (bus.i_id_rd_num),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy)
  );

  // Entry 0 never reads busy, so the x0 exemption is already in the lookups.
  assign hazard = bus.i_id_valid &
                  ((bus.i_id_uses_rs1 & rs1_busy) |
                   (bus.i_id_uses_rs2 & rs2_busy) |
                   (bus.i_id_writes_rd & rd_busy));

  always_comb begin
    cls = RUN;
    if (bus.i_mem_busy)     cls = FREEZE;
    else if (flush_pending) cls = FLUSH;
    else if (hazard)        cls = STALL;
  end

  assign issue = (cls == RUN) & bus.i_id_valid;

  always_comb begin
    bus.o_pc_en    = 1'b0;
    bus.o_if_id_en = 1'b0;
    bus.o_id_kill  = 1'b1;
    bus.o_hold     = 1'b0;
    bus.o_issue    = 1'b0;
    bus.o_state    = RUN;
    if (i_rst_n) begin
      bus.o_state = cls;
      unique case (cls)
        FREEZE: begin
          bus.o_id_kill = 1'b0;
          bus.o_hold    = 1'b1;
        end
        FLUSH: begin
          bus.o_pc_en    = 1'b1;
          bus.o_if_id_en = 1'b1;
        end
        STALL: ;
        RUN: begin
          bus.o_pc_en    = 1'b1;
          bus.o_if_id_en = 1'b1;
          bus.o_id_kill  = ~bus.i_id_valid;
          bus.o_issue    = bus.i_id_valid;
        end
        default: ;
      endcase
    end
  end

  // A frozen cycle is never FLUSH, so the pending flush waits out the freeze.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      flush_pending <= 1'b0;
      stall_cnt     <= '0;
    end else begin
      if (issue && bus.i_b_taken) flush_pending <= 1'b1;
      else if (cls == FLUSH)      flush_pending <= 1'b0;

      if (bus.i_cnt_clr)                             stall_cnt <= '0;
      else if ((cls == STALL) && (stall_cnt != '1))  stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus randomized traffic checked
// against a register-array reference model; a second DUT uses a 2-bit counter.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int REG_W   = 5;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = 65535;
  localparam int SML_MAX = 3;

  // {pc_en, if_id_en, kill, hold, issue, state}
  localparam logic [6:0] O_RESET  = 7'b0010000;
  localparam logic [6:0] O_STALL  = 7'b0010001;
  localparam logic [6:0] O_ISSUE  = 7'b1100100;
  localparam logic [6:0] O_FLUSH  = 7'b1110010;
  localparam logic [6:0] O_FREEZE = 7'b0001011;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  pipeline_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();
  pipeline_ctrl_if #(.REG_W(REG_W), .CNT_W(2))     bus_small ();

  pipeline_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
  );
  pipeline_ctrl #(.REG_W(REG_W), .CNT_W(2)) dut_small (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_small)
  );

  assign bus_small.i_id_valid     = bus.i_id_valid;
  assign bus_small.i_id_rs1_num   = bus.i_id_rs1_num;
  assign bus_small.i_id_rs2_num   = bus.i_id_rs2_num;
  assign bus_small.i_id_uses_rs1  = bus.i_id_uses_rs1;
  assign bus_small.i_id_uses_rs2  = bus.i_id_uses_rs2;
  assign bus_small.i_id_rd_num    = bus.i_id_rd_num;
  assign bus_small.i_id_writes_rd = bus.i_id_writes_rd;
  assign bus_small.i_b_taken      = bus.i_b_taken;
  assign bus_small.i_wb_valid     = bus.i_wb_valid;
  assign bus_small.i_wb_rd_num    = bus.i_wb_rd_num;
  assign bus_small.i_mem_busy     = bus.i_mem_busy;
  assign bus_small.i_cnt_clr      = bus.i_cnt_clr;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model state
  bit busy_m [32];
  bit flush_m;
  int cnt_m;
  int cnt_small_m;

  task automatic model_reset();
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    flush_m     = 1'b0;
    cnt_m       = 0;
    cnt_small_m = 0;
  endtask

  function automatic logic [1:0] model_class();
    bit hz;
    hz = bus.i_id_valid &&
         ((bus.i_id_uses_rs1  && bus.i_id_rs1_num != 0 && busy_m[bus.i_id_rs1_num]) ||
          (bus.i_id_uses_rs2  && bus.i_id_rs2_num != 0 && busy_m[bus.i_id_rs2_num]) ||
          (bus.i_id_writes_rd && bus.i_id_rd_num  != 0 && busy_m[bus.i_id_rd_num]));
    if (bus.i_mem_busy) return 2'd3;
    if (flush_m)        return 2'd2;
    if (hz)             return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [6:0] model_outputs();
    logic [1:0] c;
    if (!rst_n) return O_RESET;
    c = model_class();
    case (c)
      2'd3:    return O_FREEZE;
      2'd2:    return O_FLUSH;
      2'd1:    return O_STALL;
      default: return {1'b1, 1'b1, ~bus.i_id_valid, 1'b0, bus.i_id_valid, 2'd0};
    endcase
  endfunction

  function automatic logic [6:0] observed();
    return {bus.o_pc_en, bus.o_if_id_en, bus.o_id_kill, bus.o_hold, bus.o_issue, bus.o_state};
  endfunction

  function automatic logic [6:0] observed_small();
    return {bus_small.o_pc_en, bus_small.o_if_id_en, bus_small.o_id_kill,
            bus_small.o_hold, bus_small.o_issue, bus_small.o_state};
  endfunction

  // Step the model across one rising edge using the inputs held over it.
  task automatic advance();
    logic [1:0] c;
    bit iss;
    @(posedge clk);
    if (rst_n) begin
      c   = model_class();
      iss = (c == 2'd0) && bus.i_id_valid;
      if (iss && bus.i_b_taken) flush_m = 1'b1;
      else if (c == 2'd2)       flush_m = 1'b0;
      if (bus.i_wb_valid && bus.i_wb_rd_num != 0) busy_m[bus.i_wb_rd_num] = 1'b0;
      if (iss && bus.i_id_writes_rd && bus.i_id_rd_num != 0) busy_m[bus.i_id_rd_num] = 1'b1;
      if (bus.i_cnt_clr) begin
        cnt_m       = 0;
        cnt_small_m = 0;
      end else if (c == 2'd1) begin
        if (cnt_m < CNT_MAX)       cnt_m++;
        if (cnt_small_m < SML_MAX) cnt_small_m++;
      end
    end else begin
      model_reset();
    end
    @(negedge clk);
  endtask

  task automatic set_idle();
    bus.i_id_valid     = 1'b0;
    bus.i_id_rs1_num   = '0;
    bus.i_id_rs2_num   = '0;
    bus.i_id_uses_rs1  = 1'b0;
    bus.i_id_uses_rs2  = 1'b0;
    bus.i_id_rd_num    = '0;
    bus.i_id_writes_rd = 1'b0;
    bus.i_b_taken      = 1'b0;
    bus.i_wb_valid     = 1'b0;
    bus.i_wb_rd_num    = '0;
    bus.i_mem_busy     = 1'b0;
    bus.i_cnt_clr      = 1'b0;
  endtask

  task automatic drive_instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                             input logic u2, input logic [4:0] rd, input logic w,
                             input logic bt);
    bus.i_id_valid     = 1'b1;
    bus.i_id_rs1_num   = rs1;
    bus.i_id_uses_rs1  = u1;
    bus.i_id_rs2_num   = rs2;
    bus.i_id_uses_rs2  = u2;
    bus.i_id_rd_num    = rd;
    bus.i_id_writes_rd = w;
    bus.i_b_taken      = bt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    model_reset();
    @(negedge clk);
    #1;
    total++;
    if (observed() !== O_RESET) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%b want=%b", observed(), O_RESET);
    end
    total++;
    if (bus.o_stall_cnt !== 16'd0) begin
      bad++;
      $display("[TB] FAIL reset_cnt got=%0d want=0", bus.o_stall_cnt);
    end
    rst_n = 1'b1;
    advance();
    #1;
    total++;
    if (observed() !== 7'b1110000) begin
      bad++;
      $display("[TB] FAIL post_reset_bubble got=%b want=%b", observed(), 7'b1110000);
    end
    advance();
  endtask

  task automatic test_load_use();
    set_idle();
    drive_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    #1;
    total++;
    if (observed() !== O_ISSUE) begin
      bad++;
      $display("[TB] FAIL load_use_writer got=%b want=%b", observed(), O_ISSUE);
    end
    advance();
    drive_instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.i_wb_valid  = (i == 1);
      bus.i_wb_rd_num = 5'd5;
      #1;
      total++;
      if (observed() !== ((i < 2) ? O_STALL : O_ISSUE)) begin
        bad++;
        $display("[TB] FAIL load_use_step%0d got=%b want=%b", i, observed(),
                 (i < 2) ? O_STALL : O_ISSUE);
      end
      advance();
    end
    set_idle();
  endtask

  task automatic test_branch();
    set_idle();
    drive_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    total++;
    if (observed() !== O_ISSUE) begin
      bad++;
      $display("[TB] FAIL branch_issue got=%b want=%b", observed(), O_ISSUE);
    end
    advance();
    drive_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    total++;
    if (observed() !== O_FLUSH) begin
      bad++;
      $display("[TB] FAIL branch_flush got=%b want=%b", observed(), O_FLUSH);
    end
    advance();
    #1;
    total++;
    if (observed() !== O_ISSUE) begin
      bad++;
      $display("[TB] FAIL branch_after got=%b want=%b", observed(), O_ISSUE);
    end
    advance();
    set_idle();
  endtask

  task automatic test_freeze_flush();
    set_idle();
    drive_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    total++;
    if (observed() !== O_ISSUE) begin
      bad++;
      $display("[TB] FAIL freeze_branch got=%b want=%b", observed(), O_ISSUE);
    end
    advance();
    drive_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    bus.i_mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (observed() !== O_FREEZE) begin
        bad++;
        $display("[TB] FAIL freeze_cycle%0d got=%b want=%b", i, observed(), O_FREEZE);
      end
      advance();
    end
    bus.i_mem_busy = 1'b0;
    #1;
    total++;
    if (observed() !== O_FLUSH) begin
      bad++;
      $display("[TB] FAIL freeze_then_flush got=%b want=%b", observed(), O_FLUSH);
    end
    advance();
    #1;
    total++;
    if (observed() !== O_ISSUE) begin
      bad++;
      $display("[TB] FAIL freeze_resume got=%b want=%b", observed(), O_ISSUE);
    end
    advance();
    set_idle();
  endtask

  task automatic test_x0();
    set_idle();
    drive_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    #1;
    total++;
    if (observed() !== O_ISSUE) begin
      bad++;
      $display("[TB] FAIL x0_writer got=%b want=%b", observed(), O_ISSUE);
    end
    advance();
    drive_instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
    #1;
    total++;
    if (observed() !== O_ISSUE) begin
      bad++;
      $display("[TB] FAIL x0_reader got=%b want=%b", observed(), O_ISSUE);
    end
    advance();
    set_idle();
  endtask

  task automatic test_set_wins();
    set_idle();
    drive_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    bus.i_wb_valid  = 1'b1;
    bus.i_wb_rd_num = 5'd7;
    #1;
    total++;
    if (observed() !== O_ISSUE) begin
      bad++;
      $display("[TB] FAIL set_wins_issue got=%b want=%b", observed(), O_ISSUE);
    end
    advance();
    set_idle();
    drive_instr(5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
    #1;
    total++;
    if (observed() !== O_STALL) begin
      bad++;
      $display("[TB] FAIL set_wins_stall got=%b want=%b", observed(), O_STALL);
    end
    advance();
    bus.i_wb_valid  = 1'b1;
    bus.i_wb_rd_num = 5'd7;
    advance();
    set_idle();
  endtask

  task automatic test_stall_count();
    rst_n = 1'b0;
    set_idle();
    #1;
    total++;
    if (observed() !== O_RESET || bus.o_stall_cnt !== 16'd0) begin
      bad++;
      $display("[TB] FAIL cnt_reset got=%b/%0d want=%b/0", observed(), bus.o_stall_cnt, O_RESET);
    end
    advance();
    rst_n = 1'b1;
    drive_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    advance();
    drive_instr(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      if (i == 3) begin
        total++;
        if (bus.o_stall_cnt !== 16'd3) begin
          bad++;
          $display("[TB] FAIL cnt_three got=%0d want=3", bus.o_stall_cnt);
        end
      end
      advance();
    end
    #1;
    total++;
    if (bus.o_stall_cnt !== 16'd5) begin
      bad++;
      $display("[TB] FAIL cnt_five got=%0d want=5", bus.o_stall_cnt);
    end
    total++;
    if (bus_small.o_stall_cnt !== 2'd3) begin
      bad++;
      $display("[TB] FAIL cnt_saturate got=%0d want=3", bus_small.o_stall_cnt);
    end
    bus.i_cnt_clr = 1'b1;
    advance();
    bus.i_cnt_clr = 1'b0;
    #1;
    total++;
    if (observed() !== O_STALL || bus.o_stall_cnt !== 16'd0 || bus_small.o_stall_cnt !== 2'd0) begin
      bad++;
      $display("[TB] FAIL cnt_clear got=%b/%0d/%0d want=%b/0/0", observed(),
               bus.o_stall_cnt, bus_small.o_stall_cnt, O_STALL);
    end
    advance();
    rst_n = 1'b0;
    #1;
    total++;
    if (observed() !== O_RESET || bus.o_stall_cnt !== 16'd0) begin
      bad++;
      $display("[TB] FAIL mid_stall_reset got=%b/%0d want=%b/0", observed(), bus.o_stall_cnt, O_RESET);
    end
    advance();
    rst_n = 1'b1;
    #1;
    total++;
    if (observed() !== O_ISSUE) begin
      bad++;
      $display("[TB] FAIL post_reset_issue got=%b want=%b", observed(), O_ISSUE);
    end
    advance();
    set_idle();
  endtask

  task automatic test_random();
    logic [6:0] exp;
    set_idle();
    for (int n = 0; n < 400; n++) begin
      bus.i_id_valid     = ($urandom_range(0, 9) < 8);
      bus.i_id_rs1_num   = 5'($urandom_range(0, 7));
      bus.i_id_rs2_num   = 5'($urandom_range(0, 7));
      bus.i_id_uses_rs1  = 1'($urandom_range(0, 1));
      bus.i_id_uses_rs2  = 1'($urandom_range(0, 1));
      bus.i_id_rd_num    = 5'($urandom_range(0, 7));
      bus.i_id_writes_rd = 1'($urandom_range(0, 1));
      bus.i_b_taken      = ($urandom_range(0, 9) < 2);
      bus.i_wb_valid     = ($urandom_range(0, 9) < 4);
      bus.i_wb_rd_num    = 5'($urandom_range(0, 7));
      bus.i_mem_busy     = ($urandom_range(0, 9) == 0);
      bus.i_cnt_clr      = ($urandom_range(0, 19) == 0);
      #1;
      exp = model_outputs();
      total++;
      if (observed() !== exp || observed_small() !== exp) begin
        bad++;
        $display("[TB] FAIL random_outputs n=%0d got=%b/%b want=%b", n, observed(),
                 observed_small(), exp);
      end
      total++;
      if (bus.o_stall_cnt !== 16'(cnt_m) || bus_small.o_stall_cnt !== 2'(cnt_small_m)) begin
        bad++;
        $display("[TB] FAIL random_cnt n=%0d got=%0d/%0d want=%0d/%0d", n, bus.o_stall_cnt,
                 bus_small.o_stall_cnt, cnt_m, cnt_small_m);
      end
      advance();
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_freeze_flush();
    test_x0();
    test_set_wins();
    test_stall_count();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
